nw_score_sequencer: RTL and testbench

- Control FSM that sequences the Needleman-Wunsch score-RAM manager for a full (N+1)x(N+1) matrix fill.
- Initialises row 0 and column 0 with gap penalties.
- For every inner cell, in row-major order: fetches diag, left and up; hands them to the external cell PE; writes the PE maximum back.
- Sits between the top-level start/done interface and the score-RAM manager plus PE.

---
 rtl/nw_pkg.sv | 19 +
 rtl/nw_cell_counter.sv | 37 +++
 rtl/nw_score_sequencer.sv | 145 ++++++++++++++
 tb/tb_nw_score_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared types and constants for the Needleman-Wunsch score-matrix control blocks.
package nw_pkg;

    localparam int unsigned SCORE_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD,
        PE,
        WR,
        DONE
    } state_t;

    localparam logic [1:0] SEL_DIAG = 2'b00;
    localparam logic [1:0] SEL_LEFT = 2'b01;
    localparam logic [1:0] SEL_UP   = 2'b10;

endpackage

// File: rtl/nw_cell_counter.sv
// Row-major i/j walker over the N x N inner cells with a last-cell flag.
module nw_cell_counter #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last_c
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    assign last_c = (i == LAST) && (j == LAST);

    // Wraps back to (0,0) after the last cell so the next fill starts clean.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i <= '0;
            j <= '0;
        end else if (inc) begin
            if (last_c) begin
                i <= '0;
                j <= '0;
            end else if (j == LAST) begin
                j <= '0;
                i <= i + IW'(1);
            end else begin
                j <= j + IW'(1);
            end
        end
    end

endmodule

// File: rtl/nw_score_sequencer.sv
// Sequences score-RAM init, per-cell diag/left/up fetch, PE handshake and write-back
// for a full (N+1)x(N+1) Needleman-Wunsch matrix fill.
module nw_score_sequencer
    import nw_pkg::*;
#(
    parameter int unsigned N   = 5,
    parameter int          GAP = -1,
    parameter int unsigned IW  = $clog2(N) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               en_init,
    output logic               en_ins,
    output logic               en_read,
    output logic               we,
    output logic [IW-1:0]      addr_init,
    output logic [SCORE_W-1:0] data_init,
    output logic [IW-1:0]      i,
    output logic [IW-1:0]      j,
    output logic [1:0]         count_3,
    input  logic [SCORE_W-1:0] score,
    input  logic               valid,
    output logic               pe_req,
    output logic [SCORE_W-1:0] pe_diag,
    output logic [SCORE_W-1:0] pe_left,
    output logic [SCORE_W-1:0] pe_up,
    input  logic               pe_ack,
    input  logic [SCORE_W-1:0] pe_max,
    output logic [SCORE_W-1:0] max,
    output logic [SCORE_W-1:0] final_score
);

    localparam logic [IW-1:0]      K_LAST = IW'(N);
    localparam logic [SCORE_W-1:0] GAP_S  = SCORE_W'(GAP);

    state_t state, state_nxt;
    logic   ctr_clr_c;
    logic   ctr_inc_c;
    logic   last_c;

    nw_cell_counter #(
        .N  (N),
        .IW (IW)
    ) u_cell_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (ctr_clr_c),
        .inc    (ctr_inc_c),
        .i      (i),
        .j      (j),
        .last_c (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctr_clr_c = 1'b0;
        ctr_inc_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                    ctr_clr_c = 1'b1;
                end
            end
            INIT:    if (addr_init == K_LAST) state_nxt = RD;
            RD:      if (valid && (count_3 == SEL_UP)) state_nxt = PE;
            PE:      if (pe_ack) state_nxt = WR;
            WR: begin
                ctr_inc_c = 1'b1;
                state_nxt = last_c ? DONE : RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode the upcoming state so every output leaves a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            en_init     <= 1'b0;
            en_ins      <= 1'b0;
            en_read     <= 1'b0;
            we          <= 1'b0;
            pe_req      <= 1'b0;
            addr_init   <= '0;
            data_init   <= '0;
            count_3     <= SEL_DIAG;
            pe_diag     <= '0;
            pe_left     <= '0;
            pe_up       <= '0;
            max         <= '0;
            final_score <= '0;
        end else begin
            busy    <= state_nxt inside {INIT, RD, PE, WR};
            done    <= (state_nxt == DONE);
            en_init <= (state_nxt == INIT);
            en_ins  <= (state_nxt == WR);
            en_read <= (state_nxt == RD);
            we      <= (state_nxt == INIT) || (state_nxt == WR);
            pe_req  <= (state_nxt == PE);

            // Running accumulator gives k*GAP without a multiplier.
            if ((state == INIT) && (state_nxt == INIT)) begin
                addr_init <= addr_init + IW'(1);
                data_init <= data_init + GAP_S;
            end else begin
                addr_init <= '0;
                data_init <= '0;
            end

            if ((state == RD) && valid) begin
                case (count_3)
                    SEL_DIAG: begin
                        pe_diag <= score;
                        count_3 <= SEL_LEFT;
                    end
                    SEL_LEFT: begin
                        pe_left <= score;
                        count_3 <= SEL_UP;
                    end
                    SEL_UP: begin
                        pe_up   <= score;
                        count_3 <= SEL_DIAG;
                    end
                    default: count_3 <= SEL_DIAG;
                endcase
            end

            if ((state == PE) && pe_ack) max <= pe_max;

            if ((state == WR) && last_c) final_score <= max;
        end
    end

endmodule

// File: tb/tb_nw_score_sequencer.sv
// Directed bench: behavioural score RAM and PE around the sequencer, plus an N=1 instance.
module tb_nw_score_sequencer;
    import nw_pkg::*;

    localparam int unsigned N   = 5;
    localparam int          GAP = -1;
    localparam int unsigned IW  = $clog2(N) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic          busy, done, en_init, en_ins, en_read, we, pe_req;
    logic [IW-1:0] addr_init, i, j;
    logic [8:0]    data_init, pe_diag, pe_left, pe_up, max, final_score;
    logic [1:0]    count_3;
    logic          valid  = 1'b0;
    logic          pe_ack = 1'b0;
    logic [8:0]    score  = '0;
    logic [8:0]    pe_max = '0;

    // Single-cell instance with inputs tied permanently active.
    logic       start_1;
    logic       busy_1, done_1, en_init_1, en_ins_1, en_read_1, we_1, pe_req_1;
    logic [0:0] addr_init_1, i_1, j_1;
    logic [8:0] data_init_1, pe_diag_1, pe_left_1, pe_up_1, max_1, final_score_1;
    logic [1:0] count_3_1;
    logic       valid_1  = 1'b1;
    logic       pe_ack_1 = 1'b1;
    logic [8:0] score_1  = 9'h000;
    logic [8:0] pe_max_1 = 9'h007;

    nw_score_sequencer #(.N(N), .GAP(GAP), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .en_init(en_init), .en_ins(en_ins), .en_read(en_read), .we(we),
        .addr_init(addr_init), .data_init(data_init), .i(i), .j(j),
        .count_3(count_3), .score(score), .valid(valid), .pe_req(pe_req),
        .pe_diag(pe_diag), .pe_left(pe_left), .pe_up(pe_up),
        .pe_ack(pe_ack), .pe_max(pe_max), .max(max), .final_score(final_score)
    );

    nw_score_sequencer #(.N(1), .GAP(GAP), .IW(1)) dut_1 (
        .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .done(done_1),
        .en_init(en_init_1), .en_ins(en_ins_1), .en_read(en_read_1), .we(we_1),
        .addr_init(addr_init_1), .data_init(data_init_1), .i(i_1), .j(j_1),
        .count_3(count_3_1), .score(score_1), .valid(valid_1), .pe_req(pe_req_1),
        .pe_diag(pe_diag_1), .pe_left(pe_left_1), .pe_up(pe_up_1),
        .pe_ack(pe_ack_1), .pe_max(pe_max_1), .max(max_1), .final_score(final_score_1)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    ram  [0:N][0:N];
    int    gold [0:N][0:N];
    string seq_a = "AAAAA";
    string seq_b = "AAAAA";
    int    stall_used = 0, stall_limit = 0;
    int    pe_used = 0, pe_limit = 0;
    logic  armed = 1'b0;

    function automatic int sx(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    function automatic int pe_fn(input int d, input int l, input int u, input bit match);
        int m;
        m = d + (match ? 1 : -1);
        if (l - 1 > m) m = l - 1;
        if (u - 1 > m) m = u - 1;
        return m;
    endfunction

    // Score RAM: writes on init/insert strobes, answers each read one cycle late.
    always @(negedge clk) begin
        int ii, jj, v;
        ii = int'(i);
        jj = int'(j);
        if (en_init && we) begin
            ram[int'(addr_init)][0] = sx(data_init);
            ram[0][int'(addr_init)] = sx(data_init);
        end
        if (en_ins && we) ram[ii + 1][jj + 1] = sx(max);
        if (!en_read) begin
            valid = 1'b0;
            armed = 1'b0;
        end else if ((stall_used < stall_limit) && (count_3 == SEL_LEFT)) begin
            valid = 1'b0;
            stall_used++;
        end else if (valid || !armed) begin
            valid = 1'b0;
            armed = 1'b1;
        end else begin
            case (count_3)
                SEL_DIAG: v = ram[ii][jj];
                SEL_LEFT: v = ram[ii + 1][jj];
                default:  v = ram[ii][jj + 1];
            endcase
            score = 9'(v);
            valid = 1'b1;
        end
    end

    // Cell PE: max(diag +/-1, left-1, up-1), optionally stalling the ack.
    always @(negedge clk) begin
        if (pe_req && (pe_used < pe_limit)) begin
            pe_ack = 1'b0;
            pe_used++;
        end else if (pe_req) begin
            pe_max = 9'(pe_fn(sx(pe_diag), sx(pe_left), sx(pe_up),
                              seq_a[int'(i)] == seq_b[int'(j)]));
            pe_ack = 1'b1;
        end else begin
            pe_ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, en_init, en_ins, en_read, we, pe_req, count_3}), 64'(0));
        check({tag, "_idx"}, 64'({addr_init, data_init, i, j}), 64'(0));
        check({tag, "_dat"}, 64'({pe_diag, pe_left, pe_up, max, final_score}), 64'(0));
    endtask

    logic [8:0] init_exp [0:5] = '{9'h000, 9'h1FF, 9'h1FE, 9'h1FD, 9'h1FC, 9'h1FB};

    initial begin
        int exp_i, exp_j, writes, dones, inits, cyc, ins1;
        logic [IW-1:0] si, sj;

        rst = 1'b1;
        start = 1'b0;
        start_1 = 1'b0;
        for (int k = 0; k <= N; k++) begin
            gold[k][0] = k * GAP;
            gold[0][k] = k * GAP;
        end
        for (int r = 1; r <= N; r++)
            for (int c = 1; c <= N; c++)
                gold[r][c] = pe_fn(gold[r-1][c-1], gold[r][c-1], gold[r-1][c],
                                   seq_a[r-1] == seq_b[c-1]);

        repeat (3) tick();
        check_idle("reset");
        check("reset_n1", 64'({busy_1, done_1, en_init_1, en_ins_1, en_read_1, we_1, final_score_1}), 64'(0));
        rst = 1'b0;
        tick();

        // Run A: init sweep, first cell, full row-major fill.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= N; k++) begin
            check($sformatf("init_k%0d", k),
                  64'({en_init, we, en_read, en_ins, addr_init, data_init}),
                  64'({1'b1, 1'b1, 1'b0, 1'b0, IW'(k), init_exp[k]}));
            tick();
        end
        check("rd_entry", 64'({en_read, we, en_init, busy, i, j, count_3}),
              64'({1'b1, 1'b0, 1'b0, 1'b1, IW'(0), IW'(0), SEL_DIAG}));

        for (int c = 0; c < 50 && !pe_req; c++) tick();
        check("pe_req_cell00", 64'(pe_req), 64'(1));
        check("operands_cell00", 64'({pe_diag, pe_left, pe_up}), 64'({9'h000, 9'h1FF, 9'h1FF}));
        for (int c = 0; c < 20 && !en_ins; c++) tick();
        check("write_cell00", 64'({en_ins, we, i, j, max}), 64'({1'b1, 1'b1, IW'(0), IW'(0), 9'h001}));
        tick();
        check("write_one_cycle", 64'({en_ins, we}), 64'(0));

        exp_i = 0; exp_j = 1; writes = 1; dones = 0;
        for (int c = 0; c < 2000 && dones == 0; c++) begin
            tick();
            if (en_ins) begin
                check($sformatf("write_%0d_%0d", exp_i, exp_j), 64'({i, j, max}),
                      64'({IW'(exp_i), IW'(exp_j), 9'(gold[exp_i+1][exp_j+1])}));
                writes++;
                if (exp_j == N - 1) begin
                    exp_j = 0;
                    exp_i++;
                end else begin
                    exp_j++;
                end
            end
            if (done) dones++;
        end
        repeat (5) begin
            tick();
            if (done) dones++;
        end
        check("fill_writes", 64'(writes), 64'(25));
        check("fill_dones", 64'(dones), 64'(1));
        check("fill_final", 64'(final_score), 64'(9'h005));
        check("fill_idle", 64'({busy, en_read, en_ins, we}), 64'(0));

        // Run B: read stall at the left fetch, PE ack stall, start pulse during PE.
        stall_limit = stall_used + 4;
        pe_limit = pe_used + 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && !(en_read && count_3 == SEL_LEFT); c++) tick();
        check("stall_found", 64'(en_read && count_3 == SEL_LEFT), 64'(1));
        si = i;
        sj = j;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("stall_hold%0d", s), 64'({count_3, i, j, en_ins, en_read}),
                  64'({SEL_LEFT, si, sj, 1'b0, 1'b1}));
        end
        for (int c = 0; c < 50 && !pe_req; c++) tick();
        check("pe_wait_found", 64'(pe_req), 64'(1));
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("pe_hold%0d", s), 64'({pe_req, en_ins, we}), 64'({1'b1, 1'b0, 1'b0}));
            start = (s == 0);
        end
        start = 1'b0;
        tick();
        check("pe_ack_write", 64'({en_ins, we, i, j}), 64'({1'b1, 1'b1, IW'(0), IW'(0)}));
        tick();
        check("pe_ack_one_write", 64'(en_ins), 64'(0));
        dones = 0; inits = 0;
        for (int c = 0; c < 2000 && dones == 0; c++) begin
            tick();
            if (done) dones++;
            if (en_init) inits++;
        end
        repeat (5) begin
            tick();
            if (done) dones++;
        end
        check("restart_ignored", 64'(inits), 64'(0));
        check("stall_dones", 64'(dones), 64'(1));
        check("stall_final", 64'(final_score), 64'(9'h005));

        // Run C: reset while reading cell (2,3), then a clean restart.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && !(en_read && i == IW'(2) && j == IW'(3)); c++) tick();
        check("cell23_found", 64'(en_read && i == IW'(2) && j == IW'(3)), 64'(1));
        rst = 1'b1;
        tick();
        check_idle("reset_mid");
        rst = 1'b0;
        tick();
        check("post_reset_idle", 64'({busy, en_init, we}), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_k0", 64'({en_init, we, addr_init, data_init}), 64'({1'b1, 1'b1, IW'(0), 9'h000}));
        dones = 0;
        for (int c = 0; c < 2000 && dones == 0; c++) begin
            tick();
            if (done) dones++;
        end
        check("restart_final", 64'({dones[0], final_score}), 64'({1'b1, 9'h005}));

        // Run D: N=1, valid/pe_ack always high -> 2 init + 3 read + PE + WR.
        start_1 = 1'b1;
        tick();
        start_1 = 1'b0;
        cyc = 0;
        ins1 = 0;
        while (!done_1 && cyc < 50) begin
            tick();
            cyc++;
            if (en_ins_1) ins1++;
        end
        check("n1_latency", 64'(cyc), 64'(7));
        check("n1_writes", 64'(ins1), 64'(1));
        check("n1_final", 64'(final_score_1), 64'(9'h007));
        tick();
        check("n1_done_pulse", 64'({done_1, busy_1}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
